// File: rtl/jt7759_pkg.sv
// Shared types and tables for the jt7759 ADPCM nibble decoder.
// Optional feature macro used by the top level: JT7759_UNDERRUN_EN.
package jt7759_pkg;

    localparam int SAMPLE_W = 9;
    localparam int ST_W     = 4;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_HI    = 2'd1,
        BUF_LO    = 2'd2
    } buf_state_e;

    // Row = predictor step index, column = 4-bit code; entries 8..15 mirror 0..7 negated.
    localparam logic signed [10:0] STEP [16][16] = '{
        '{11'sd0, 11'sd0,  11'sd1,  11'sd2,  11'sd3,  11'sd5,   11'sd7,   11'sd10,  11'sd0,  11'sd0,   -11'sd1,  -11'sd2,  -11'sd3,  -11'sd5,   -11'sd7,   -11'sd10},
        '{11'sd0, 11'sd1,  11'sd2,  11'sd3,  11'sd4,  11'sd6,   11'sd8,   11'sd13,  11'sd0,  -11'sd1,  -11'sd2,  -11'sd3,  -11'sd4,  -11'sd6,   -11'sd8,   -11'sd13},
        '{11'sd0, 11'sd1,  11'sd2,  11'sd4,  11'sd5,  11'sd7,   11'sd10,  11'sd15,  11'sd0,  -11'sd1,  -11'sd2,  -11'sd4,  -11'sd5,  -11'sd7,   -11'sd10,  -11'sd15},
        '{11'sd0, 11'sd1,  11'sd3,  11'sd4,  11'sd6,  11'sd9,   11'sd13,  11'sd19,  11'sd0,  -11'sd1,  -11'sd3,  -11'sd4,  -11'sd6,  -11'sd9,   -11'sd13,  -11'sd19},
        '{11'sd0, 11'sd2,  11'sd3,  11'sd5,  11'sd8,  11'sd11,  11'sd15,  11'sd23,  11'sd0,  -11'sd2,  -11'sd3,  -11'sd5,  -11'sd8,  -11'sd11,  -11'sd15,  -11'sd23},
        '{11'sd0, 11'sd2,  11'sd4,  11'sd7,  11'sd10, 11'sd14,  11'sd19,  11'sd29,  11'sd0,  -11'sd2,  -11'sd4,  -11'sd7,  -11'sd10, -11'sd14,  -11'sd19,  -11'sd29},
        '{11'sd0, 11'sd3,  11'sd5,  11'sd8,  11'sd12, 11'sd16,  11'sd22,  11'sd33,  11'sd0,  -11'sd3,  -11'sd5,  -11'sd8,  -11'sd12, -11'sd16,  -11'sd22,  -11'sd33},
        '{11'sd1, 11'sd4,  11'sd7,  11'sd10, 11'sd15, 11'sd20,  11'sd29,  11'sd43,  -11'sd1, -11'sd4,  -11'sd7,  -11'sd10, -11'sd15, -11'sd20,  -11'sd29,  -11'sd43},
        '{11'sd1, 11'sd4,  11'sd8,  11'sd13, 11'sd18, 11'sd25,  11'sd35,  11'sd53,  -11'sd1, -11'sd4,  -11'sd8,  -11'sd13, -11'sd18, -11'sd25,  -11'sd35,  -11'sd53},
        '{11'sd1, 11'sd6,  11'sd10, 11'sd16, 11'sd22, 11'sd31,  11'sd43,  11'sd64,  -11'sd1, -11'sd6,  -11'sd10, -11'sd16, -11'sd22, -11'sd31,  -11'sd43,  -11'sd64},
        '{11'sd2, 11'sd7,  11'sd12, 11'sd19, 11'sd27, 11'sd37,  11'sd51,  11'sd76,  -11'sd2, -11'sd7,  -11'sd12, -11'sd19, -11'sd27, -11'sd37,  -11'sd51,  -11'sd76},
        '{11'sd2, 11'sd9,  11'sd16, 11'sd24, 11'sd34, 11'sd46,  11'sd64,  11'sd96,  -11'sd2, -11'sd9,  -11'sd16, -11'sd24, -11'sd34, -11'sd46,  -11'sd64,  -11'sd96},
        '{11'sd3, 11'sd11, 11'sd19, 11'sd29, 11'sd41, 11'sd57,  11'sd79,  11'sd117, -11'sd3, -11'sd11, -11'sd19, -11'sd29, -11'sd41, -11'sd57,  -11'sd79,  -11'sd117},
        '{11'sd4, 11'sd13, 11'sd24, 11'sd36, 11'sd50, 11'sd69,  11'sd96,  11'sd143, -11'sd4, -11'sd13, -11'sd24, -11'sd36, -11'sd50, -11'sd69,  -11'sd96,  -11'sd143},
        '{11'sd4, 11'sd16, 11'sd29, 11'sd44, 11'sd62, 11'sd85,  11'sd118, 11'sd175, -11'sd4, -11'sd16, -11'sd29, -11'sd44, -11'sd62, -11'sd85,  -11'sd118, -11'sd175},
        '{11'sd6, 11'sd20, 11'sd36, 11'sd54, 11'sd76, 11'sd104, 11'sd144, 11'sd214, -11'sd6, -11'sd20, -11'sd36, -11'sd54, -11'sd76, -11'sd104, -11'sd144, -11'sd214}
    };

    localparam logic signed [3:0] DELTA [8] = '{
        -4'sd1, -4'sd1, 4'sd0, 4'sd0, 4'sd1, 4'sd2, 4'sd2, 4'sd3
    };

endpackage

// File: rtl/jt7759_adpcm_core.sv
// Registered ADPCM predictor: owns the sample and step index, clamps both,
// and clears synchronously.
module jt7759_adpcm_core
    import jt7759_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_i,
    input  logic                dec_i,
    input  logic [3:0]          nibble_i,
    output logic [SAMPLE_W-1:0] sample_o
);

    logic signed [SAMPLE_W-1:0] sample_q, sample_d;
    logic        [ST_W-1:0]     st_q, st_d;
    logic signed [10:0]         step_s;
    logic signed [3:0]          delta_s;
    logic signed [9:0]          sum_s;
    logic signed [5:0]          st_sum_s;

    // Next predictor state: table lookups, 10-bit sum, then saturation.
    always_comb begin
        sample_d = sample_q;
        st_d     = st_q;
        step_s   = STEP[st_q][nibble_i];
        delta_s  = DELTA[nibble_i[2:0]];
        // Table magnitudes stay below 256, so the low 10 bits hold the full value.
        sum_s    = $signed({sample_q[SAMPLE_W-1], sample_q}) + $signed(step_s[9:0]);
        st_sum_s = $signed({2'b00, st_q}) + $signed({{2{delta_s[3]}}, delta_s});
        if (clr_i) begin
            sample_d = 9'sd0;
            st_d     = 4'd0;
        end else if (dec_i) begin
            if (sum_s > 10'sd255) begin
                sample_d = 9'sd255;
            end else if (sum_s < -10'sd256) begin
                sample_d = -9'sd256;
            end else begin
                sample_d = sum_s[SAMPLE_W-1:0];
            end
            if (st_sum_s < 6'sd0) begin
                st_d = 4'd0;
            end else if (st_sum_s > 6'sd15) begin
                st_d = 4'd15;
            end else begin
                st_d = st_sum_s[ST_W-1:0];
            end
        end else begin
            sample_d = sample_q;
            st_d     = st_q;
        end
    end

    // Predictor registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_q <= 9'sd0;
            st_q     <= 4'd0;
        end else begin
            sample_q <= sample_d;
            st_q     <= st_d;
        end
    end

    assign sample_o = sample_q;

endmodule

// File: rtl/jt7759_nibble_dec.sv
// ADPCM byte buffer, handshake and decode sequencing for the uPD7759 core.
// Define JT7759_UNDERRUN_EN to build the sticky underrun flag.
module jt7759_nibble_dec
    import jt7759_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                cendec,
    input  logic                restart,
    input  logic [7:0]          byte_in,
    input  logic                byte_ok,
    output logic                byte_rdy,
    output logic [SAMPLE_W-1:0] sound,
    output logic                underrun
);

    buf_state_e  state_q, state_d;
    logic [7:0]  byte_q, byte_d;
    logic        byte_rdy_q;
    logic        dec_s;
    logic [3:0]  nibble_s;
`ifdef JT7759_UNDERRUN_EN
    logic        urun_set_s;
    logic        underrun_q;
`endif

    // Buffer FSM: restart wins; a strobe in EMPTY never consumes the byte loaded that cycle.
    always_comb begin
        state_d  = state_q;
        byte_d   = byte_q;
        dec_s    = 1'b0;
        nibble_s = (state_q == BUF_HI) ? byte_q[7:4] : byte_q[3:0];
`ifdef JT7759_UNDERRUN_EN
        urun_set_s = 1'b0;
`endif
        if (restart) begin
            state_d = BUF_EMPTY;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (byte_ok) begin
                        state_d = BUF_HI;
                        byte_d  = byte_in;
                    end else begin
                        state_d = BUF_EMPTY;
                    end
`ifdef JT7759_UNDERRUN_EN
                    if (cendec) begin
                        urun_set_s = 1'b1;
                    end else begin
                        urun_set_s = 1'b0;
                    end
`endif
                end
                BUF_HI: begin
                    if (cendec) begin
                        dec_s   = 1'b1;
                        state_d = BUF_LO;
                    end else begin
                        state_d = BUF_HI;
                    end
                end
                BUF_LO: begin
                    if (cendec) begin
                        dec_s   = 1'b1;
                        state_d = BUF_EMPTY;
                    end else begin
                        state_d = BUF_LO;
                    end
                end
                default: begin
                    state_d = BUF_EMPTY;
                end
            endcase
        end
    end

    // Buffer state, held byte and registered ready flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= BUF_EMPTY;
            byte_q     <= 8'd0;
            byte_rdy_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            byte_q     <= byte_d;
            byte_rdy_q <= (state_d == BUF_EMPTY);
        end
    end

    assign byte_rdy = byte_rdy_q;

`ifdef JT7759_UNDERRUN_EN
    // Sticky underrun, cleared only by restart or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underrun_q <= 1'b0;
        end else if (restart) begin
            underrun_q <= 1'b0;
        end else if (urun_set_s) begin
            underrun_q <= 1'b1;
        end else begin
            underrun_q <= underrun_q;
        end
    end

    assign underrun = underrun_q;
`else
    assign underrun = 1'b0;
`endif

    jt7759_adpcm_core u_core (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (restart),
        .dec_i    (dec_s),
        .nibble_i (nibble_s),
        .sample_o (sound)
    );

endmodule

// File: tb/tb_jt7759_nibble_dec.sv
// Self-checking bench for jt7759_nibble_dec: queue-based reference model
// compared every cycle, plus hand-computed literal checkpoints.
module tb_jt7759_nibble_dec;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cendec = 1'b0;
    logic       restart = 1'b0;
    logic [7:0] byte_in = 8'h00;
    logic       byte_ok = 1'b0;
    logic       byte_rdy;
    logic [8:0] sound;
    logic       underrun;

    int errors = 0;
    int checks = 0;

`ifdef JT7759_UNDERRUN_EN
    localparam int UR_ON = 1;
`else
    localparam int UR_ON = 0;
`endif

    // Step magnitudes for codes 0..7; codes 8..15 use the same magnitude negated.
    int stepm [16][8] = '{
        '{0,0,1,2,3,5,7,10},      '{0,1,2,3,4,6,8,13},
        '{0,1,2,4,5,7,10,15},     '{0,1,3,4,6,9,13,19},
        '{0,2,3,5,8,11,15,23},    '{0,2,4,7,10,14,19,29},
        '{0,3,5,8,12,16,22,33},   '{1,4,7,10,15,20,29,43},
        '{1,4,8,13,18,25,35,53},  '{1,6,10,16,22,31,43,64},
        '{2,7,12,19,27,37,51,76}, '{2,9,16,24,34,46,64,96},
        '{3,11,19,29,41,57,79,117}, '{4,13,24,36,50,69,96,143},
        '{4,16,29,44,62,85,118,175}, '{6,20,36,54,76,104,144,214}
    };
    int dlt [8] = '{-1,-1,0,0,1,2,2,3};

    int m_q[$];
    int m_s  = 0;
    int m_st = 0;
    int m_ur = 0;

    jt7759_nibble_dec dut (
        .clk      (clk),
        .rst      (rst),
        .cendec   (cendec),
        .restart  (restart),
        .byte_in  (byte_in),
        .byte_ok  (byte_ok),
        .byte_rdy (byte_rdy),
        .sound    (sound),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending nibbles as a queue, predictor as plain integers.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_s = 0; m_st = 0; m_ur = 0;
        end else if (restart) begin
            m_q.delete();
            m_s = 0; m_st = 0; m_ur = 0;
        end else begin
            bit was_empty;
            was_empty = (m_q.size() == 0);
            if (cendec) begin
                if (m_q.size() > 0) begin
                    int n;
                    int mag;
                    n = m_q.pop_front();
                    mag = stepm[m_st][n % 8];
                    m_s = m_s + ((n >= 8) ? -mag : mag);
                    if (m_s > 255) m_s = 255;
                    if (m_s < -256) m_s = -256;
                    m_st = m_st + dlt[n % 8];
                    if (m_st < 0) m_st = 0;
                    if (m_st > 15) m_st = 15;
                end else begin
                    m_ur = UR_ON;
                end
            end
            if (byte_ok && was_empty) begin
                m_q.push_back(int'(byte_in[7:4]));
                m_q.push_back(int'(byte_in[3:0]));
            end
        end
    end

    // Cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        chk("sound", int'($signed(sound)), m_s);
        chk("byte_rdy", int'(byte_rdy), (m_q.size() == 0) ? 1 : 0);
        chk("underrun", int'(underrun), m_ur);
    end

    task automatic cyc(input logic cen, input logic rs, input logic bok, input logic [7:0] b);
        cendec = cen; restart = rs; byte_ok = bok; byte_in = b;
        @(negedge clk);
        cendec = 1'b0; restart = 1'b0; byte_ok = 1'b0;
    endtask

    initial begin
        int prev;
        int viol;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        chk("rst_sound", int'($signed(sound)), 0);
        chk("rst_rdy", int'(byte_rdy), 1);
        chk("rst_ur", int'(underrun), 0);

        // Strobe with nothing buffered.
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk("empty_ur", int'(underrun), UR_ON);
        chk("empty_sound", int'($signed(sound)), 0);

        // 0x44: +3 then +4.
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 8'h44);
        chk("acc_rdy", int'(byte_rdy), 0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk("dec44_hi", int'($signed(sound)), 3);
        chk("dec44_rdy_lo", int'(byte_rdy), 0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk("dec44_lo", int'($signed(sound)), 7);
        chk("dec44_rdy", int'(byte_rdy), 1);

        // 0x77 stream, byte_ok held high throughout, strobe every other cycle.
        prev = 7; viol = 0;
        for (int i = 0; i < 80; i++) begin
            cyc(logic'(i % 2), 1'b0, 1'b1, 8'h77);
            if (int'($signed(sound)) < prev) viol++;
            prev = int'($signed(sound));
        end
        chk("rise_mono", viol, 0);
        chk("rise_sat", int'($signed(sound)), 255);

        // 0xFF stream after high saturation.
        for (int i = 0; i < 20; i++) begin
            cyc(logic'(i % 2), 1'b0, 1'b1, 8'hFF);
        end
        chk("fall_sat", int'($signed(sound)), -256);

        // Restart while HI with sound=7; coincident strobe and byte ignored.
        cyc(1'b0, 1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 8'h44);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 8'h44);
        chk("pre_rs_sound", int'($signed(sound)), 7);
        cyc(1'b1, 1'b1, 1'b1, 8'h12);
        chk("rs_sound", int'($signed(sound)), 0);
        chk("rs_rdy", int'(byte_rdy), 1);
        chk("rs_ur", int'(underrun), 0);

        // Same-cycle accept and strobe in EMPTY.
        cyc(1'b1, 1'b0, 1'b1, 8'h44);
        chk("same_ur", int'(underrun), UR_ON);
        chk("same_rdy", int'(byte_rdy), 0);
        chk("same_sound", int'($signed(sound)), 0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk("same_dec", int'($signed(sound)), 3);

        // Asynchronous reset mid-decode.
        #2 rst = 1'b1;
        #1;
        chk("arst_sound", int'($signed(sound)), 0);
        chk("arst_rdy", int'(byte_rdy), 1);
        chk("arst_ur", int'(underrun), 0);
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b1, 8'h44);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk("post_arst", int'($signed(sound)), 3);
        cyc(1'b0, 1'b0, 1'b0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
